// File: rtl/sl_leaf_target.sv
// Leaf responder of the same-latency interconnect tree: zero-fills its bank after reset,
// then serves writes and fixed-latency reads, with saturating access counters.

package sl_pkg;
    localparam int SL_AW = 32;
    localparam int SL_DW = 32;

    typedef struct packed {
        logic             wen;
        logic [SL_AW-1:0] waddr;
        logic [SL_DW-1:0] wdata;
    } sl_wreq_t;

    typedef struct packed {
        logic             ren;
        logic [SL_AW-1:0] raddr;
    } sl_rreq_t;

    typedef struct packed {
        sl_wreq_t wreq;
        sl_rreq_t rreq;
    } SL_REQ;

    typedef struct packed {
        logic             rvalid;
        logic [SL_DW-1:0] rdata;
    } SL_RES;
endpackage

module sl_leaf_target
    import sl_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 0,
    parameter int RD_LAT   = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  SL_REQ            req_up,
    output SL_RES            res_up,
    output logic             init_done,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] oor_cnt
);
    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_V = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_ptr;
    logic [SL_DW-1:0] mem [DEPTH];

    logic [IDX_W-1:0] widx, ridx;
    logic             w_in, r_in, run, wr_hit;
    logic [SL_DW-1:0] rd_data_d;
    logic             rd_inc, wr_inc;
    logic [1:0]       oor_inc;

    logic             pipe_vld  [RD_LAT];
    logic [SL_DW-1:0] pipe_data [RD_LAT];

    assign widx   = req_up.wreq.waddr[ADDR_LSB +: IDX_W];
    assign ridx   = req_up.rreq.raddr[ADDR_LSB +: IDX_W];
    assign w_in   = {1'b0, widx} < DEPTH_V;
    assign r_in   = {1'b0, ridx} < DEPTH_V;
    assign run    = (state == ST_RUN);
    assign wr_hit = req_up.wreq.wen && w_in && (widx == ridx);

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        rd_data_d = '0;
        if (req_up.rreq.ren && run && r_in)
            rd_data_d = wr_hit ? req_up.wreq.wdata : mem[ridx];
    end

    always_comb begin
        rd_inc  = req_up.rreq.ren;
        wr_inc  = run && req_up.wreq.wen && w_in;
        oor_inc = 2'(run && req_up.wreq.wen && !w_in) + 2'(run && req_up.rreq.ren && !r_in);
    end

    // NOTE: the bank has no reset; its contents become defined only through the INIT sweep.
    always_ff @(posedge clk) begin
        if (!run)
            mem[init_ptr] <= '0;
        else if (req_up.wreq.wen && w_in)
            mem[widx] <= req_up.wreq.wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= run;
            if (!run) begin
                init_ptr <= init_ptr + 1'b1;
                if (init_ptr == LAST_IX)
                    state <= ST_RUN;
            end
        end
    end

    // Invalid stages carry zero data so the parent can OR/merge responses by rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= req_up.rreq.ren;
            pipe_data[0] <= rd_data_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign res_up = {pipe_vld[RD_LAT-1], pipe_data[RD_LAT-1]};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            oor_cnt <= '0;
        end else begin
            rd_cnt  <= sat_add(rd_cnt, {1'b0, rd_inc});
            wr_cnt  <= sat_add(wr_cnt, {1'b0, wr_inc});
            oor_cnt <= sat_add(oor_cnt, oor_inc);
        end
    end

endmodule
